// File: rtl/io_out_pkg.sv
// io_out_pkg
// Shared types and constants for the output-pad serializer.
//   io_out_state_t : serializer FSM states (idle, driver lead-in, shifting, trail-out)
//   PRBS7_SEED     : value the PRBS7 generator restarts from after reset
//   PRBS7_TAPS     : feedback taps for x^7 + x^6 + 1 (register bits 6 and 5)
//   PAD_T_DRIVE    : pad tristate control level that enables the output driver
//   PAD_T_HIZ      : pad tristate control level that releases the pad
package io_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL
    } io_out_state_t;

    localparam logic [6:0] PRBS7_SEED = 7'h7F;
    localparam logic [6:0] PRBS7_TAPS = 7'b110_0000;

    localparam logic PAD_T_DRIVE = 1'b0;
    localparam logic PAD_T_HIZ   = 1'b1;

    // Feedback bit of the PRBS7 shift register: XOR of the tapped bits.
    function automatic logic prbs7_feedback(input logic [6:0] state);
        return ^(state & PRBS7_TAPS);
    endfunction

endpackage

// File: rtl/io_out_prbs7.sv
// io_out_prbs7
// PRBS7 (x^7 + x^6 + 1) pattern source used to keep the pad toggling while the
// serializer has no word to send. The register shifts left, so bit 6 is the
// oldest bit and is the one presented on bit_out.
//   clk     : clock
//   rst     : synchronous active-high reset, reloads the seed
//   advance : step the generator by one bit at the next clock edge
//   bit_out : current PRBS bit
module io_out_prbs7
    import io_out_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic advance,
    output logic bit_out
);

    logic [6:0] lfsr;

    // Generator state: seeded on reset and stepped only when asked to, so the
    // serializer can freeze the stream while it is sending a word.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr <= PRBS7_SEED;
        end else if (advance) begin
            lfsr <= {lfsr[5:0], prbs7_feedback(lfsr)};
        end
    end

    assign bit_out = lfsr[6];

endmodule

// File: rtl/io_out_serializer.sv
// io_out_serializer
// Fabric-side driver stage for a single output/tristate pad buffer. Accepts
// parallel words over valid/ready and shifts them out LSB-first onto the pad
// data line, each bit held DIV clocks. The pad driver is enabled LEAD_CYC
// clocks before the first bit and released TRAIL_CYC clocks after the last.
// Words presented on the final clock of the final bit follow on immediately
// with no lead-in or trail-out between them.
//
// Optional feature: define IO_OUT_SERIALIZER_PRBS_EN to keep the pad driven
// with a PRBS7 stream while idle instead of tristating it. The stream freezes
// while a word is in flight and resumes where it stopped.
//
// Ports:
//   clk      : sole clock
//   rst      : synchronous active-high reset
//   in_valid : a word is offered on in_data
//   in_data  : word to send, sampled only on the handshake
//   in_ready : word accepted on a clock with in_valid & in_ready
//   pad_do   : registered pad data (to PADDO)
//   pad_t    : registered pad tristate control (to PADT), 1 = high impedance
//   busy     : serializer is anywhere other than idle
module io_out_serializer
    import io_out_pkg::*;
#(
    parameter int   DATA_W     = 8,
    parameter int   DIV        = 1,
    parameter int   LEAD_CYC   = 2,
    parameter int   TRAIL_CYC  = 2,
    parameter logic IDLE_LEVEL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              pad_do,
    output logic              pad_t,
    output logic              busy
);

    localparam int DIV_CW = $clog2(DIV) + 1;
    localparam int BIT_CW = $clog2(DATA_W) + 1;

    localparam logic [DIV_CW-1:0] DIV_LAST   = DIV_CW'(DIV - 1);
    localparam logic [BIT_CW-1:0] BIT_LAST   = BIT_CW'(DATA_W - 1);
    localparam logic [3:0]        LEAD_LAST  = 4'(LEAD_CYC - 1);
    localparam logic [3:0]        TRAIL_LAST = 4'(TRAIL_CYC - 1);

    io_out_state_t     state;
    io_out_state_t     state_nxt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_nxt;
    logic [DIV_CW-1:0] div_cnt;
    logic [DIV_CW-1:0] div_cnt_nxt;
    logic [BIT_CW-1:0] bit_cnt;
    logic [BIT_CW-1:0] bit_cnt_nxt;
    logic [3:0]        gap_cnt;
    logic [3:0]        gap_cnt_nxt;
    logic              pad_do_nxt;
    logic              pad_t_nxt;
    logic              handshake;
    logic              last_beat;

`ifdef IO_OUT_SERIALIZER_PRBS_EN
    logic              prbs_adv;
    logic              prbs_bit;
    logic [DIV_CW-1:0] idle_div;

    // The div counter is shared with the idle PRBS bit timing; on the first
    // idle clock after a frame it restarts from zero.
    assign idle_div = (state == ST_IDLE) ? div_cnt : '0;

    io_out_prbs7 u_prbs7 (
        .clk     (clk),
        .rst     (rst),
        .advance (prbs_adv),
        .bit_out (prbs_bit)
    );
`endif

    // The final clock of the final bit is the only busy clock that can take
    // the next word. Ready is held low while reset is asserted.
    assign last_beat = (state == ST_SHIFT) && (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);
    assign in_ready  = ~rst & ((state == ST_IDLE) | last_beat);
    assign handshake = in_valid & in_ready;
    assign busy      = (state != ST_IDLE);

    // State, counters, shift register and the pad output registers. The pad
    // registers are loaded from the next-state decode so they line up with the
    // state they describe and carry no combinational path from the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            shreg   <= '0;
            div_cnt <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            pad_do  <= IDLE_LEVEL;
            pad_t   <= PAD_T_HIZ;
        end else begin
            state   <= state_nxt;
            shreg   <= shreg_nxt;
            div_cnt <= div_cnt_nxt;
            bit_cnt <= bit_cnt_nxt;
            gap_cnt <= gap_cnt_nxt;
            pad_do  <= pad_do_nxt;
            pad_t   <= pad_t_nxt;
        end
    end

    // Sequencing: lead-in and trail-out share one gap counter, the div counter
    // times each bit, and the bit counter selects when a word is finished. A
    // handshake on the last beat reloads the register and stays in SHIFT.
    always_comb begin
        state_nxt   = state;
        shreg_nxt   = shreg;
        div_cnt_nxt = div_cnt;
        bit_cnt_nxt = bit_cnt;
        gap_cnt_nxt = gap_cnt;
`ifdef IO_OUT_SERIALIZER_PRBS_EN
        prbs_adv    = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (handshake) begin
                    shreg_nxt   = in_data;
                    div_cnt_nxt = '0;
                    bit_cnt_nxt = '0;
                    gap_cnt_nxt = '0;
                    state_nxt   = (LEAD_CYC == 0) ? ST_SHIFT : ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (gap_cnt == LEAD_LAST) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = ST_SHIFT;
                end else begin
                    gap_cnt_nxt = gap_cnt + 4'd1;
                end
            end
            ST_SHIFT: begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt_nxt = div_cnt + DIV_CW'(1);
                end else begin
                    div_cnt_nxt = '0;
                    if (bit_cnt != BIT_LAST) begin
                        bit_cnt_nxt = bit_cnt + BIT_CW'(1);
                        shreg_nxt   = shreg >> 1;
                    end else begin
                        bit_cnt_nxt = '0;
                        gap_cnt_nxt = '0;
                        if (handshake) begin
                            shreg_nxt = in_data;
                        end else begin
                            state_nxt = (TRAIL_CYC == 0) ? ST_IDLE : ST_TRAIL;
                        end
                    end
                end
            end
            ST_TRAIL: begin
                if (gap_cnt == TRAIL_LAST) begin
                    gap_cnt_nxt = '0;
                    state_nxt   = ST_IDLE;
                end else begin
                    gap_cnt_nxt = gap_cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
`ifdef IO_OUT_SERIALIZER_PRBS_EN
        // While staying or arriving in idle, each PRBS bit is presented for DIV
        // clocks; leaving idle on a handshake freezes the generator.
        if (state_nxt == ST_IDLE) begin
            prbs_adv    = (idle_div == DIV_LAST);
            div_cnt_nxt = prbs_adv ? '0 : idle_div + DIV_CW'(1);
        end
`endif
    end

    // Pad levels for the clock being entered: data only while shifting, the
    // idle level during lead-in and trail-out, and either high impedance or the
    // PRBS stream while idle.
    always_comb begin
        pad_t_nxt  = PAD_T_DRIVE;
        pad_do_nxt = IDLE_LEVEL;
        case (state_nxt)
            ST_SHIFT: begin
                pad_do_nxt = shreg_nxt[0];
            end
            ST_IDLE: begin
`ifdef IO_OUT_SERIALIZER_PRBS_EN
                pad_do_nxt = prbs_bit;
`else
                pad_t_nxt  = PAD_T_HIZ;
`endif
            end
            default: begin
                pad_do_nxt = IDLE_LEVEL;
            end
        endcase
    end

endmodule
